// File: rtl/ram32_32_pkg.sv
// Shared widths and types for the 32x32 register file.
// Optional macro: RAM32_32_ZERO_REG_EN (entry 0 hardwired to zero).
package ram32_32_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DEPTH  = 2 ** ADDR_W;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/ram32_32.sv
// 32-entry x 32-bit register file: two combinational read ports, one synchronous write port.
// Build option: define RAM32_32_ZERO_REG_EN to hardwire entry 0 to zero (x0 semantics).
module ram32_32
    import ram32_32_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              WE3,
    input  logic [ADDR_W-1:0] A1,
    input  logic [ADDR_W-1:0] A2,
    input  logic [ADDR_W-1:0] A3,
    input  logic [DATA_W-1:0] WD3,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2
);

    word_t mem [DEPTH];
    logic  wr_en;

`ifdef RAM32_32_ZERO_REG_EN
    assign wr_en = WE3 && (A3 != '0);
`else
    assign wr_en = WE3;
`endif

    // Reset wins over a write presented on the same edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[A3] <= WD3;
        end
    end

    // No write-through: a same-address read shows the old word until the edge.
    always_comb begin
`ifdef RAM32_32_ZERO_REG_EN
        RD1 = (A1 == '0) ? '0 : mem[A1];
        RD2 = (A2 == '0) ? '0 : mem[A2];
`else
        RD1 = mem[A1];
        RD2 = mem[A2];
`endif
    end

endmodule

// File: tb/tb_ram32_32.sv
// Self-checking bench for ram32_32: scoreboard queue of expected read data.
// Honours RAM32_32_ZERO_REG_EN when the same macro is defined for the build.
module tb_ram32_32;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        WE3 = 1'b0;
    logic [4:0]  A1  = '0;
    logic [4:0]  A2  = '0;
    logic [4:0]  A3  = '0;
    logic [31:0] WD3 = '0;
    logic [31:0] RD1;
    logic [31:0] RD2;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [32];
    logic [31:0] exp_q [$];
    logic [31:0] exp_v;

    ram32_32 dut (
        .CLK(CLK), .RST(RST), .WE3(WE3),
        .A1(A1), .A2(A2), .A3(A3), .WD3(WD3),
        .RD1(RD1), .RD2(RD2)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] model_rd(input logic [4:0] a);
`ifdef RAM32_32_ZERO_REG_EN
        if (a == 5'd0) return 32'd0;
`endif
        return model[a];
    endfunction

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge CLK);
        WE3 = 1'b1; A3 = a; WD3 = d;
        @(posedge CLK);
        #1;
        WE3 = 1'b0;
`ifdef RAM32_32_ZERO_REG_EN
        if (a != 5'd0) model[a] = d;
`else
        model[a] = d;
`endif
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 32; i++) begin
            A1 = 5'(i);
            A2 = 5'(31 - i);
            exp_q.push_back(32'd0);
            exp_q.push_back(32'd0);
            #1;
            exp_v = exp_q.pop_front();
            checks++;
            if (RD1 !== exp_v) begin
                errors++;
                $display("FAIL reset_rd1 addr=%0d got=%h exp=%h", A1, RD1, exp_v);
            end
            exp_v = exp_q.pop_front();
            checks++;
            if (RD2 !== exp_v) begin
                errors++;
                $display("FAIL reset_rd2 addr=%0d got=%h exp=%h", A2, RD2, exp_v);
            end
        end
    endtask

    task automatic test_write_read();
        do_write(5'd0, 32'd30);
        do_write(5'd10, 32'd228);
        do_write(5'd21, 32'd1337);
        A1 = 5'd10; A2 = 5'd21;
        exp_q.push_back(32'd228);
        exp_q.push_back(32'd1337);
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (RD1 !== exp_v) begin
            errors++;
            $display("FAIL wr_rd1 got=%0d exp=%0d", RD1, exp_v);
        end
        exp_v = exp_q.pop_front();
        checks++;
        if (RD2 !== exp_v) begin
            errors++;
            $display("FAIL wr_rd2 got=%0d exp=%0d", RD2, exp_v);
        end
        // Entry 0: 30 normally, 0 when hardwired.
        A1 = 5'd0; A2 = 5'd0;
`ifdef RAM32_32_ZERO_REG_EN
        exp_q.push_back(32'd0);
`else
        exp_q.push_back(32'd30);
`endif
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (RD1 !== exp_v || RD2 !== exp_v) begin
            errors++;
            $display("FAIL wr_addr0 rd1=%0d rd2=%0d exp=%0d", RD1, RD2, exp_v);
        end
        // Same address on both ports.
        A1 = 5'd21; A2 = 5'd21;
        exp_q.push_back(model_rd(5'd21));
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (RD1 !== exp_v || RD2 !== exp_v) begin
            errors++;
            $display("FAIL same_addr rd1=%0d rd2=%0d exp=%0d", RD1, RD2, exp_v);
        end
    endtask

    task automatic test_truncation();
        logic [7:0] wide;
        wide = 8'd100;
        do_write(wide[4:0], 32'd1488);
        A2 = 5'd4;
        exp_q.push_back(32'd1488);
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (RD2 !== exp_v) begin
            errors++;
            $display("FAIL trunc_100 got=%0d exp=%0d", RD2, exp_v);
        end
        wide = 8'd42;
        A1 = wide[4:0];
        exp_q.push_back(32'd228);
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (RD1 !== exp_v) begin
            errors++;
            $display("FAIL trunc_42 got=%0d exp=%0d", RD1, exp_v);
        end
    endtask

    task automatic test_write_disable();
        @(negedge CLK);
        WE3 = 1'b0; A3 = 5'd10; WD3 = 32'hDEADBEEF;
        @(posedge CLK);
        #1;
        A1 = 5'd10;
        exp_q.push_back(32'd228);
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (RD1 !== exp_v) begin
            errors++;
            $display("FAIL write_disable got=%h exp=%h", RD1, exp_v);
        end
    endtask

    task automatic test_read_during_write();
        @(negedge CLK);
        A1 = 5'd5; A3 = 5'd5; WE3 = 1'b1; WD3 = 32'h55;
        exp_q.push_back(model_rd(5'd5));
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (RD1 !== exp_v) begin
            errors++;
            $display("FAIL rdw_before got=%h exp=%h", RD1, exp_v);
        end
        @(posedge CLK);
        #1;
        WE3 = 1'b0;
        model[5] = 32'h55;
        exp_q.push_back(32'h55);
        exp_v = exp_q.pop_front();
        checks++;
        if (RD1 !== exp_v) begin
            errors++;
            $display("FAIL rdw_after got=%h exp=%h", RD1, exp_v);
        end
    endtask

    task automatic test_reset_priority();
        do_write(5'd7, 32'h77);
        @(negedge CLK);
        RST = 1'b1; WE3 = 1'b1; A3 = 5'd7; WD3 = 32'd9;
        @(posedge CLK);
        #1;
        RST = 1'b0; WE3 = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        A1 = 5'd7; A2 = 5'd10;
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (RD1 !== exp_v) begin
            errors++;
            $display("FAIL rst_prio_e7 got=%h exp=%h", RD1, exp_v);
        end
        exp_v = exp_q.pop_front();
        checks++;
        if (RD2 !== exp_v) begin
            errors++;
            $display("FAIL rst_prio_e10 got=%h exp=%h", RD2, exp_v);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 32; i++) do_write(5'(i), 32'h1000_0000 + 32'(i * 3));
        for (int i = 0; i < 32; i++) begin
            A1 = 5'(i);
            A2 = 5'(i ^ 5'h1F);
            exp_q.push_back(model_rd(5'(i)));
            exp_q.push_back(model_rd(5'(i ^ 5'h1F)));
            #1;
            exp_v = exp_q.pop_front();
            checks++;
            if (RD1 !== exp_v) begin
                errors++;
                $display("FAIL b2b_rd1 addr=%0d got=%h exp=%h", A1, RD1, exp_v);
            end
            exp_v = exp_q.pop_front();
            checks++;
            if (RD2 !== exp_v) begin
                errors++;
                $display("FAIL b2b_rd2 addr=%0d got=%h exp=%h", A2, RD2, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_truncation();
        test_write_disable();
        test_read_during_write();
        test_reset_priority();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
